// File: rtl/segled_bcd_prep.sv
// segled_bcd_prep: sequential double-dabble binary-to-BCD converter feeding a 4-digit seven-segment driver
module segled_bcd_prep #(
  parameter int          IN_WIDTH   = 14,
  parameter int          MAX_VAL    = 9999,
  parameter logic [7:0]  BLANK_CODE = 8'hFF,
  parameter bit          LZ_BLANK   = 1'b0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [IN_WIDTH-1:0] bin_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                busy,
  output logic [31:0]         disp_data,
  output logic                disp_upd
);
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);
  localparam logic [31:0] MAX_U = MAX_VAL;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [IN_WIDTH-1:0] sreg_q, sreg_d;
  logic [15:0] bcd_q, bcd_d, bcd_adj;
  logic [IN_WIDTH+15:0] shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [31:0] disp_q, disp_d, fmt;
  logic upd_q, upd_d;
  logic lz3, lz2, lz1;
  for (genvar n = 0; n < 4; n++) begin : g_adj
    assign bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] >= 4'd5 ? bcd_q[4*n +: 4] + 4'd3 : bcd_q[4*n +: 4];
  end
  assign shifted = {bcd_adj, sreg_q} << 1;
  // leading-zero chain: a digit blanks only if every more significant digit is also zero
  always_comb begin
    lz3 = LZ_BLANK && bcd_q[15:12] == 4'd0;
    lz2 = lz3 && bcd_q[11:8] == 4'd0;
    lz1 = lz2 && bcd_q[7:4] == 4'd0;
    fmt = ovf_q ? {4{BLANK_CODE}} :
          {lz3 ? BLANK_CODE : {4'h0, bcd_q[15:12]},
           lz2 ? BLANK_CODE : {4'h0, bcd_q[11:8]},
           lz1 ? BLANK_CODE : {4'h0, bcd_q[7:4]},
           {4'h0, bcd_q[3:0]}};
  end
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    upd_d   = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SHIFT;
        sreg_d  = bin_in;
        bcd_d   = 16'h0;
        cnt_d   = '0;
        ovf_d   = 32'(bin_in) > MAX_U;
      end
      SHIFT: begin
        bcd_d   = shifted[IN_WIDTH+15:IN_WIDTH];
        sreg_d  = shifted[IN_WIDTH-1:0];
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == LAST ? DONE : SHIFT;
      end
      DONE: begin
        disp_d  = fmt;
        upd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= 32'h0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      upd_q   <= upd_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign disp_data = disp_q;
  assign disp_upd  = upd_q;
endmodule
